// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan display: hex glyph table and width helper.
package seven_seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-high glyphs, bit0 = a ... bit6 = g; entry 15 (F) first.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   assign seg_n = ~SEG_HEX[nib];

endmodule

// File: rtl/seven_seg_scan_display.sv
// Time-multiplexed N-digit hex display with frame-synchronous update, dp, zero blanking and anti-ghost gap.
module seven_seg_scan_display
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    disp_en,
   input  logic                    lz_en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done,
   output logic                    commit
);

   localparam int PW = idx_w(REFRESH_DIV);
   localparam int IW = idx_w(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_P   = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] val;
      logic [NUM_DIGITS-1:0]      dp;
   } frame_t;

   logic [PW-1:0]                presc;
   logic [IW-1:0]                idx;
   frame_t                       active, pending;
   logic                         pend_vld;
   logic                         tick, boundary, lit;
   logic [NUM_DIGITS:0]          zero_from;
   logic [NUM_DIGITS-1:0]        sup, an_sel;
   logic [NUM_DIGITS-1:0][6:0]   dig_seg_n;

   assign tick     = (presc == PRESC_MAX);
   assign boundary = tick && (idx == IDX_MAX);

   // zero_from[k]: every active nibble from k up to the leftmost digit is zero.
   assign zero_from[NUM_DIGITS] = 1'b1;
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      assign zero_from[k] = (active.val[k] == 4'h0) && zero_from[k+1];
      if (k == 0) begin : g_d0
         assign sup[k] = 1'b0;
      end else begin : g_dk
         assign sup[k] = lz_en && zero_from[k] && !active.dp[k];
      end
      hex_to_seg7 u_dec (.nib(active.val[k]), .seg_n(dig_seg_n[k]));
   end

   assign an_sel = NUM_DIGITS'(1) << idx;
   assign lit    = disp_en && (presc >= BLANK_P) && !sup[idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc      <= '0;
         idx        <= '0;
         active     <= '0;
         pending    <= '0;
         pend_vld   <= 1'b0;
         an_n       <= '1;
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
         commit     <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

         frame_done <= boundary;
         commit     <= boundary && pend_vld;
         if (boundary && pend_vld) active <= pending;

         // A load on the committing edge stays pending for the next frame.
         if (load) begin
            pending  <= {value_in, dp_in};
            pend_vld <= 1'b1;
         end else if (boundary) begin
            pend_vld <= 1'b0;
         end

         an_n  <= lit ? ~an_sel : '1;
         seg_n <= lit ? dig_seg_n[idx] : SEG_OFF;
         dp_n  <= lit ? ~active.dp[idx] : 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Directed bench with a commit scoreboard and a per-cycle display monitor.
module tb_seven_seg_scan_display;

   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 1;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic           clk = 1'b0, rst = 1'b1, disp_en = 1'b1, lz_en = 1'b0, load = 1'b0;
   logic [4*N-1:0] value_in = '0;
   logic [N-1:0]   dp_in = '0;
   logic [6:0]     seg_n;
   logic           dp_n, frame_done, commit;
   logic [N-1:0]   an_n;

   seven_seg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .disp_en(disp_en), .lz_en(lz_en), .load(load),
      .value_in(value_in), .dp_in(dp_in), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
      .frame_done(frame_done), .commit(commit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4*N-1:0] val;
      logic [N-1:0]   dp;
      int             stamp;
   } ent_t;

   ent_t           q[$];
   logic [4*N-1:0] cur_val = '0;
   logic [N-1:0]   cur_dp = '0;
   int             nvec = 0, nerr = 0, cyc = 0, pos = 0;
   logic           de_q = 1'b1, lz_q = 1'b0;

   int             md, mp;
   logic           mallz, msup, mlit, mexp_c;
   logic [N-1:0]   mexp_an;
   logic [6:0]     mexp_seg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_an_n", 32'(an_n), 32'hF);
      chk("rst_seg_n", 32'(seg_n), 32'h7F);
      chk("rst_dp_n", 32'(dp_n), 32'h1);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      chk("rst_commit", 32'(commit), 32'h0);
   endtask

   // pos = 1..4N: output slot within the frame; the slot at pos reflects edge pos.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      de_q <= disp_en;
      lz_q <= lz_en;
      if (rst) pos <= 0;
      else     pos <= (pos == R*N) ? 1 : pos + 1;
   end

   always @(negedge clk) begin
      if (!rst && pos != 0) begin
         md = (pos - 1) / R;
         mp = (pos - 1) % R;
         mallz = 1'b1;
         for (int k = md; k < N; k++)
            if (cur_val[k*4 +: 4] != 4'h0) mallz = 1'b0;
         msup = lz_q && (md != 0) && mallz && !cur_dp[md];
         mlit = de_q && (mp >= B) && !msup;
         mexp_an  = mlit ? ~(N'(1) << md) : '1;
         mexp_seg = mlit ? ~HEX[cur_val[md*4 +: 4]] : 7'h7F;
         chk("an_n", 32'(an_n), 32'(mexp_an));
         if (de_q) begin
            chk("seg_n", 32'(seg_n), 32'(mexp_seg));
            chk("dp_n", 32'(dp_n), mlit ? 32'(!cur_dp[md]) : 32'h1);
         end
         mexp_c = (pos == R*N) && (q.size() > 0) && (q[0].stamp < cyc);
         chk("frame_done", 32'(frame_done), 32'(pos == R*N));
         chk("commit", 32'(commit), 32'(mexp_c));
         if (mexp_c) begin
            cur_val = q[0].val;
            cur_dp  = q[0].dp;
            void'(q.pop_front());
         end
      end
   end

   task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d, input bit ow);
      value_in = v;
      dp_in    = d;
      load     = 1'b1;
      if (ow && q.size() > 0) q[q.size()-1] = ent_t'{v, d, cyc + 1};
      else                    q.push_back(ent_t'{v, d, cyc + 1});
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 3*R*N);
      if (!frame_done) chk("frame_timeout", 32'(frame_done), 32'h1);
   endtask

   task automatic wait_pos(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pos != p && n < 3*R*N);
      if (pos != p) chk("pos_timeout", 32'(pos), 32'(p));
   endtask

   initial begin
      // reset held, then release and load one value
      repeat (3) @(posedge clk);
      #1 chk_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      do_load(16'h12AF, 4'b0000, 1'b0);
      wait_frame();
      wait_frame();
      wait_frame();

      // leading-zero suppression
      lz_en = 1'b1;
      do_load(16'h0050, 4'b0000, 1'b0);
      wait_frame(); wait_frame();
      do_load(16'h0000, 4'b0000, 1'b0);
      wait_frame(); wait_frame();
      do_load(16'h0007, 4'b0100, 1'b0);
      wait_frame(); wait_frame();

      // last load before a boundary wins
      lz_en = 1'b0;
      repeat (3) @(negedge clk);
      do_load(16'h1111, 4'b0000, 1'b0);
      repeat (2) @(negedge clk);
      do_load(16'h2222, 4'b0011, 1'b1);
      wait_frame(); wait_frame();

      // load coincident with a committing boundary
      repeat (2) @(negedge clk);
      do_load(16'h3333, 4'b0000, 1'b0);
      wait_pos(R*N - 1);
      do_load(16'h4C5D, 4'b1000, 1'b0);
      wait_frame(); wait_frame(); wait_frame();

      // display disable keeps scanning
      repeat (5) @(negedge clk);
      disp_en = 1'b0;
      repeat (10) @(negedge clk);
      disp_en = 1'b1;
      wait_frame(); wait_frame();

      // async reset mid-frame discards pending and active
      repeat (3) @(negedge clk);
      do_load(16'hBEEF, 4'b1111, 1'b0);
      #2 rst = 1'b1;
      q.delete();
      cur_val = '0;
      cur_dp  = '0;
      #1 chk_reset();
      @(posedge clk);
      #1 chk_reset();
      rst = 1'b0;
      wait_frame(); wait_frame();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, vectors=%0d miscompares=%0d", nvec, nerr);
      $fatal(1, "watchdog");
   end

endmodule
